// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, the legal word-count limit
// and the byte2 bits that must be zero.
package loader_pkg;

   localparam int MAX_WORDS = 4096;

   // Only byte2[2:0] carry instruction bits; anything set above them is a malformed word.
   localparam logic [7:0] B2_RSVD_MASK = 8'hF8;

   typedef enum logic [3:0] {
      HDR_LO,
      HDR_HI,
      B0,
      B1,
      B2,
      WRITE,
      CHK,
      DONE,
      ERROR
   } state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master side is the loader; the slave side is the byte source plus the memory.
interface instruction_loader_if #(
   parameter int ADDR_W  = 12,
   parameter int INSTR_W = 19
);
   logic               byte_valid;
   logic [7:0]         byte_data;
   logic               byte_ready;
   logic               imem_we;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_wdata;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instruction_loader.sv
// Purpose: parse a counted, checksummed byte stream into instruction-memory writes, then release core_rst.
// Latency: one cycle per accepted byte, one WRITE cycle per word, done/error registered one edge later.
// Backpressure: byte_ready drops during WRITE and stays low once DONE or ERROR is reached.
module instruction_loader #(
   parameter int ADDR_W    = 12,
   parameter int INSTR_W   = 19,
   parameter int MAX_WORDS = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   instruction_loader_if.master bus,
   output logic                 core_rst,
   output logic                 done,
   output logic                 error
);
   import loader_pkg::*;

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t          state;
   logic [15:0]     count;
   logic [ADDR_W:0] idx;
   logic [7:0]      csum;
   logic [15:0]     asm_lo;

   logic            xfer;
   logic [15:0]     hdr_n;
   logic [ADDR_W:0] idx_inc;
   logic            last_word;

   assign xfer    = bus.byte_valid & bus.byte_ready;
   assign hdr_n   = {bus.byte_data, count[7:0]};
   assign idx_inc = idx + (ADDR_W + 1)'(1);
   // idx carries one extra bit so a full MAX_WORDS load still compares correctly.
   assign last_word = (32'(idx_inc) == 32'(count));

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= HDR_LO;
         count          <= '0;
         idx            <= '0;
         csum           <= '0;
         asm_lo         <= '0;
         bus.byte_ready <= 1'b1;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         core_rst       <= 1'b1;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         case (state)
            HDR_LO: begin
               if (xfer) begin
                  count[7:0] <= bus.byte_data;
                  csum       <= bus.byte_data;
                  state      <= HDR_HI;
               end
            end
            HDR_HI: begin
               if (xfer) begin
                  count[15:8] <= bus.byte_data;
                  csum        <= csum ^ bus.byte_data;
                  if (hdr_n == 16'd0) begin
                     state <= CHK;
                  end else if ({1'b0, hdr_n} > MAX_N) begin
                     state          <= ERROR;
                     bus.byte_ready <= 1'b0;
                     error          <= 1'b1;
                  end else begin
                     state <= B0;
                  end
               end
            end
            B0: begin
               if (xfer) begin
                  asm_lo[7:0] <= bus.byte_data;
                  csum        <= csum ^ bus.byte_data;
                  state       <= B1;
               end
            end
            B1: begin
               if (xfer) begin
                  asm_lo[15:8] <= bus.byte_data;
                  csum         <= csum ^ bus.byte_data;
                  state        <= B2;
               end
            end
            B2: begin
               if (xfer) begin
                  if ((bus.byte_data & B2_RSVD_MASK) != 8'h00) begin
                     state          <= ERROR;
                     bus.byte_ready <= 1'b0;
                     error          <= 1'b1;
                  end else begin
                     csum           <= csum ^ bus.byte_data;
                     bus.imem_wdata <= INSTR_W'({bus.byte_data[2:0], asm_lo});
                     bus.imem_addr  <= idx[ADDR_W-1:0];
                     bus.imem_we    <= 1'b1;
                     bus.byte_ready <= 1'b0;
                     state          <= WRITE;
                  end
               end
            end
            WRITE: begin
               bus.imem_we    <= 1'b0;
               bus.byte_ready <= 1'b1;
               idx            <= idx_inc;
               state          <= last_word ? CHK : B0;
            end
            CHK: begin
               if (xfer) begin
                  bus.byte_ready <= 1'b0;
                  if (bus.byte_data == csum) begin
                     state    <= DONE;
                     core_rst <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
            end
            DONE, ERROR: begin
               // Terminal until rst; incoming bytes are refused.
            end
            default: begin
               state          <= ERROR;
               bus.byte_ready <= 1'b0;
               bus.imem_we    <= 1'b0;
               core_rst       <= 1'b1;
               done           <= 1'b0;
               error          <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: table of whole streams plus hand-written
// sequences for header timing, reset abort, full-size load and load latency.
module tb_instruction_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic core_rst, done, error;

   always #5 clk = ~clk;

   instruction_loader_if #(.ADDR_W(12), .INSTR_W(19)) bus ();

   instruction_loader #(.ADDR_W(12), .INSTR_W(19), .MAX_WORDS(4096)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .core_rst (core_rst),
      .done     (done),
      .error    (error)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [11:0] wr_a [$];
   logic [18:0] wr_d [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_a.push_back(bus.imem_addr);
         wr_d.push_back(bus.imem_wdata);
      end
   end

   typedef struct {
      string       name;
      int          len;
      logic [95:0] bytes;
      int          nwr;
      logic [11:0] a0;
      logic [18:0] d0;
      logic [11:0] a1;
      logic [18:0] d1;
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst            = 1'b1;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_byte_ready", {31'b0, bus.byte_ready}, 32'd1);
      check("rst_imem_we",    {31'b0, bus.imem_we},    32'd0);
      check("rst_core_rst",   {31'b0, core_rst},       32'd1);
      check("rst_done",       {31'b0, done},           32'd0);
      check("rst_error",      {31'b0, error},          32'd0);
      wr_a.delete();
      wr_d.delete();
   endtask

   // Entered and left at a falling edge; waits out byte_ready=0 cycles up to a bound.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      repeat (gap) @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      waited = 0;
      while (bus.byte_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (bus.byte_ready !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL byte_accept: byte %0h not accepted within 20 cycles", b);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h5A;
   endtask

   function automatic vec_t mk(input string nm, input int len, input logic [95:0] b, input int nwr,
                               input logic [18:0] d0, input logic [18:0] d1,
                               input logic ed, input logic ee);
      vec_t v;
      v.name = nm;  v.len = len;  v.bytes = b;  v.nwr = nwr;
      v.a0 = 12'd0; v.d0 = d0;    v.a1 = 12'd1; v.d1 = d1;
      v.exp_done = ed; v.exp_err = ee;
      return v;
   endfunction

   initial begin
      logic [7:0]  cs;
      logic [31:0] iv;
      int          bad;
      int          start;

      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;

      vecs[0] = mk("load2",  9, 96'h02_00_0D_2A_05_FF_FF_07_27_00_00_00, 2, 19'h52A0D, 19'h7FFFF, 1'b1, 1'b0);
      vecs[1] = mk("badsum", 9, 96'h02_00_0D_2A_05_FF_FF_07_26_00_00_00, 2, 19'h52A0D, 19'h7FFFF, 1'b0, 1'b1);
      vecs[2] = mk("empty",  3, 96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, 19'h0,     19'h0,     1'b1, 1'b0);
      vecs[3] = mk("one",    6, 96'h01_00_34_12_03_24_00_00_00_00_00_00, 1, 19'h31234, 19'h0,     1'b1, 1'b0);
      vecs[4] = mk("rsvd",   5, 96'h01_00_11_22_08_00_00_00_00_00_00_00, 0, 19'h0,     19'h0,     1'b0, 1'b1);
      vecs[5] = mk("toobig", 2, 96'h01_10_00_00_00_00_00_00_00_00_00_00, 0, 19'h0,     19'h0,     1'b0, 1'b1);

      foreach (vecs[v]) begin
         do_reset();
         for (int i = 0; i < vecs[v].len; i++)
            send_byte(vecs[v].bytes[95-8*i -: 8], 0);
         repeat (3) @(negedge clk);
         check({vecs[v].name, "_nwr"}, wr_a.size(), vecs[v].nwr);
         if (vecs[v].nwr > 0 && wr_a.size() > 0) begin
            check({vecs[v].name, "_a0"}, {20'b0, wr_a[0]}, {20'b0, vecs[v].a0});
            check({vecs[v].name, "_d0"}, {13'b0, wr_d[0]}, {13'b0, vecs[v].d0});
         end
         if (vecs[v].nwr > 1 && wr_a.size() > 1) begin
            check({vecs[v].name, "_a1"}, {20'b0, wr_a[1]}, {20'b0, vecs[v].a1});
            check({vecs[v].name, "_d1"}, {13'b0, wr_d[1]}, {13'b0, vecs[v].d1});
         end
         check({vecs[v].name, "_done"},     {31'b0, done},           {31'b0, vecs[v].exp_done});
         check({vecs[v].name, "_error"},    {31'b0, error},          {31'b0, vecs[v].exp_err});
         check({vecs[v].name, "_core_rst"}, {31'b0, core_rst},       {31'b0, ~vecs[v].exp_done});
         check({vecs[v].name, "_ready"},    {31'b0, bus.byte_ready}, 32'd0);
         // Terminal state must ignore further traffic.
         bus.byte_valid = 1'b1;
         bus.byte_data  = 8'h00;
         repeat (4) @(negedge clk);
         bus.byte_valid = 1'b0;
         check({vecs[v].name, "_sticky_done"},  {31'b0, done},  {31'b0, vecs[v].exp_done});
         check({vecs[v].name, "_sticky_error"}, {31'b0, error}, {31'b0, vecs[v].exp_err});
         check({vecs[v].name, "_sticky_nwr"},   wr_a.size(),    vecs[v].nwr);
      end

      // Oversized header: error must be visible right after the COUNT_HI edge.
      do_reset();
      send_byte(8'h01, 0);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h10;
      @(posedge clk);
      #1;
      check("hdr_big_error", {31'b0, error},          32'd1);
      check("hdr_big_ready", {31'b0, bus.byte_ready}, 32'd0);
      @(negedge clk);
      bus.byte_valid = 1'b0;

      // Reset in the middle of a word, then a clean load with random valid gaps.
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_rst_ready", {31'b0, bus.byte_ready}, 32'd1);
      check("abort_rst_error", {31'b0, error},          32'd0);
      for (int i = 0; i < 9; i++)
         send_byte(vecs[0].bytes[95-8*i -: 8], int'($urandom_range(0, 3)));
      repeat (3) @(negedge clk);
      check("abort_nwr", wr_a.size(), 32'd2);
      if (wr_a.size() == 2) begin
         check("abort_a0", {20'b0, wr_a[0]}, 32'h0);
         check("abort_d0", {13'b0, wr_d[0]}, 32'h52A0D);
         check("abort_a1", {20'b0, wr_a[1]}, 32'h1);
         check("abort_d1", {13'b0, wr_d[1]}, 32'h7FFFF);
      end
      check("abort_done", {31'b0, done}, 32'd1);

      // Minimum latency: COUNT_LO presented in cycle 1, done high in cycle 9+2+1.
      do_reset();
      start = cyc;
      for (int i = 0; i < 9; i++)
         send_byte(vecs[0].bytes[95-8*i -: 8], 0);
      for (int k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);
      check("latency_cycles", cyc - start + 1, 32'd12);

      // Exactly MAX_WORDS words: header accepted, every address written, done.
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h10, 0);
      check("max_hdr_error", {31'b0, error}, 32'd0);
      cs = 8'h10;
      for (int i = 0; i < 4096; i++) begin
         iv = i;
         send_byte(iv[7:0], 0);
         send_byte({4'hA, iv[11:8]}, 0);
         send_byte({5'b0, iv[2:0]}, 0);
         cs = cs ^ iv[7:0] ^ {4'hA, iv[11:8]} ^ {5'b0, iv[2:0]};
      end
      send_byte(cs, 0);
      repeat (3) @(negedge clk);
      check("max_nwr", wr_a.size(), 32'd4096);
      bad = 0;
      for (int i = 0; i < wr_a.size(); i++) begin
         iv = i;
         if (wr_a[i] !== iv[11:0] || wr_d[i] !== {iv[2:0], 4'hA, iv[11:8], iv[7:0]})
            bad++;
      end
      check("max_bad_words", bad, 32'd0);
      check("max_done", {31'b0, done}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter ADDR_W, default 12, instruction-memory address width (matches PC width).
REQ-002 Parameter INSTR_W, default 19, instruction width.
REQ-003 Parameter MAX_WORDS, default 4096, largest legal word count.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 byte_valid  in  1  upstream byte stream holds a valid byte.
REQ-007 byte_data  in  8  byte payload.
REQ-008 byte_ready  out  1  loader accepts a byte this cycle.
REQ-009 imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  out  ADDR_W  write address.
REQ-011 imem_wdata  out  INSTR_W  write data.
REQ-012 core_rst  out  1  holds the processor datapath in reset until load completes.
REQ-013 done  out  1  load finished successfully.
REQ-014 error  out  1  load aborted on a protocol error.

Function
REQ-015 A byte SHALL transfer only on a rising edge with byte_valid=1 and byte_ready=1; byte_data SHALL be ignored otherwise.
REQ-016 The stream format SHALL be: COUNT_LO, COUNT_HI (16-bit word count N), then N groups of 3 bytes, then one checksum byte.
REQ-017 Word assembly: byte0 -> instr[7:0], byte1 -> instr[15:8], byte2[2:0] -> instr[18:16].
REQ-018 byte2[7:3] not zero SHALL cause the ERROR state, with no write for that word.
REQ-019 N > MAX_WORDS SHALL cause ERROR on the edge that accepts COUNT_HI.
REQ-020 States: HDR_LO, HDR_HI, B0, B1, B2, WRITE, CHK, DONE, ERROR.
REQ-021 byte_ready SHALL be 1 in HDR_LO, HDR_HI, B0, B1, B2 and CHK, and 0 in WRITE, DONE and ERROR.
REQ-022 Transitions: HDR_LO->HDR_HI->(N=0: CHK; N>MAX_WORDS: ERROR; else B0); B0->B1->B2->WRITE (or ERROR per REQ-018); WRITE->(index==N: CHK; else B0); CHK->(match: DONE; else ERROR).
REQ-023 In WRITE, imem_we SHALL be 1 for exactly one cycle, with imem_addr = word index (0-based) and imem_wdata = the assembled word; the index SHALL increment on leaving WRITE.
REQ-024 The checksum SHALL be the 8-bit XOR of every byte from COUNT_LO through the last byte2; the CHK byte SHALL equal it.
REQ-025 imem_we SHALL be 0 outside WRITE; imem_addr and imem_wdata are don't-care when imem_we=0.
REQ-026 DONE and ERROR SHALL be sticky until rst, and further bytes SHALL be ignored.
REQ-027 core_rst SHALL be 1 in every state except DONE; done=1 only in DONE; error=1 only in ERROR; all three SHALL be registered.
REQ-028 Minimum load latency: one cycle per byte plus one WRITE cycle per word plus one cycle to enter DONE.
REQ-029 With N=MAX_WORDS the word index SHALL reach MAX_WORDS without ADDR_W overflow corrupting the comparison; the index register is ADDR_W+1 bits.

Reset
REQ-030 rst=1 at any edge, including mid-load, SHALL force HDR_LO, clear the index, count and checksum, and set byte_ready=1, imem_we=0, core_rst=1, done=0, error=0.
REQ-031 A partially received word SHALL never be written after rst.

Structure
REQ-032 The state enum, MAX_WORDS and the byte2 reserved-bit mask SHALL live in a shared package, loader_pkg.
REQ-033 The block SHALL be a single module with no sub-module; the checksum and word assembler SHALL be inline registers.

Verification
REQ-034 Stream 02 00 0D 2A 05 FF FF 07 27 -> writes addr0=0x52A0D and addr1=0x7FFFF, then done=1 and core_rst=0.
REQ-035 Same stream with checksum 26 -> both writes occur, then error=1, done=0 and core_rst=1 stay held.
REQ-036 Stream 00 00 00 -> no imem_we, then done=1.
REQ-037 Header 01 10 (N=0x1001) -> error=1 on the next cycle and byte_ready=0.
REQ-038 Stream 01 00 11 22 08 -> error=1 and no imem_we pulse.
REQ-039 rst pulse after 01 00 AA BB, then the REQ-034 stream with random byte_valid gaps -> no write from the aborted load, the same two writes as REQ-034, and done=1.
